// File: rtl/tx_byte_arbiter.sv
// Round-robin arbiter that shares one byte-wide transmitter among NREQ sources.
// Sends one byte per grant, with a start-ack timeout and an idle gap after each byte.
module tx_byte_arbiter #(
  parameter int NREQ        = 4,
  parameter int GAP_CYCLES  = 2,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic [NREQ-1:0]   i_req_valid,
  input  logic [8*NREQ-1:0] i_req_data,
  output logic [NREQ-1:0]   o_req_ready,
  output logic [7:0]        o_data,
  output logic              o_act,
  input  logic              i_busy,
  output logic [2:0]        o_grant_id,
  output logic              o_active,
  output logic              o_err
);
  localparam int IW       = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int TW       = $clog2(ACK_TIMEOUT + 1);
  localparam int GW       = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int GAP_LAST = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    ISSUE      = 3'd1,
    WAIT_START = 3'd2,
    WAIT_DONE  = 3'd3,
    GAP        = 3'd4
  } state_t;

  // With no gap configured, a finished or abandoned byte returns straight to arbitration.
  localparam state_t POST_BYTE = (GAP_CYCLES > 0) ? GAP : IDLE;

  state_t        state, state_nxt;
  logic [IW-1:0] last, grant, idx;
  logic          grant_vld, hit;
  logic [TW-1:0] tcnt, tcnt_nxt;
  logic [GW-1:0] gcnt, gcnt_nxt;
  logic          err_nxt;

  // Round-robin search starting just after the last granted requester.
  always_comb begin
    grant     = last;
    grant_vld = 1'b0;
    idx       = '0;
    hit       = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      idx       = IW'((int'(last) + k) % NREQ);
      hit       = ~grant_vld & i_req_valid[idx];
      grant     = hit ? idx : grant;
      grant_vld = grant_vld | hit;
    end
  end

  // Accept is offered only while arbitrating.
  always_comb begin
    o_req_ready = '0;
    if (state == IDLE && grant_vld) begin
      o_req_ready[grant] = 1'b1;
    end else begin
      o_req_ready = '0;
    end
  end

  // Next-state, timeout and gap counting.
  always_comb begin
    state_nxt = state;
    tcnt_nxt  = tcnt;
    gcnt_nxt  = gcnt;
    err_nxt   = o_err;
    case (state)
      IDLE: begin
        if (grant_vld) begin
          state_nxt = ISSUE;
        end else begin
          state_nxt = IDLE;
        end
      end
      ISSUE: begin
        state_nxt = WAIT_START;
        tcnt_nxt  = '0;
      end
      WAIT_START: begin
        if (i_busy) begin
          state_nxt = WAIT_DONE;
        end else begin
          tcnt_nxt = (tcnt == TW'(ACK_TIMEOUT)) ? tcnt : tcnt + TW'(1);
          if (tcnt >= TW'(ACK_TIMEOUT - 1)) begin
            err_nxt   = 1'b1;
            state_nxt = POST_BYTE;
            gcnt_nxt  = '0;
          end else begin
            state_nxt = WAIT_START;
          end
        end
      end
      WAIT_DONE: begin
        if (!i_busy) begin
          state_nxt = POST_BYTE;
          gcnt_nxt  = '0;
        end else begin
          state_nxt = WAIT_DONE;
        end
      end
      GAP: begin
        if (gcnt == GW'(GAP_LAST)) begin
          state_nxt = IDLE;
        end else begin
          gcnt_nxt = gcnt + GW'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, counters and registered outputs; strobe/active are registered from next state.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state      <= IDLE;
      last       <= IW'(NREQ - 1);
      tcnt       <= '0;
      gcnt       <= '0;
      o_data     <= 8'h00;
      o_grant_id <= 3'd0;
      o_err      <= 1'b0;
      o_act      <= 1'b0;
      o_active   <= 1'b0;
    end else begin
      state    <= state_nxt;
      tcnt     <= tcnt_nxt;
      gcnt     <= gcnt_nxt;
      o_err    <= err_nxt;
      o_act    <= (state_nxt == ISSUE);
      o_active <= (state_nxt != IDLE);
      if (state == IDLE && grant_vld) begin
        o_data     <= i_req_data[{grant, 3'b000} +: 8];
        o_grant_id <= 3'(grant);
        last       <= grant;
      end else begin
        o_data     <= o_data;
        o_grant_id <= o_grant_id;
        last       <= last;
      end
    end
  end

endmodule

// File: tb/tb_tx_byte_arbiter.sv
// Directed bench for tx_byte_arbiter: default build with a transmitter model,
// plus a zero-gap build driven by hand.
module tb_tx_byte_arbiter;
  logic        clk;
  logic        rst;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic [7:0]  o_data;
  logic        o_act;
  logic        busy_model;
  logic [2:0]  o_grant_id;
  logic        o_active;
  logic        o_err;

  logic [3:0]  valid2;
  logic [31:0] data2;
  logic [3:0]  ready2;
  logic [7:0]  dout2;
  logic        act2;
  logic        busy2;
  logic [2:0]  gid2;
  logic        active2;
  logic        err2;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  bit         tx_en  = 1'b1;
  int         tx_ack = 2;
  int         tx_len = 10;
  int         want [4] = '{default: 0};
  int         taken [4] = '{default: 0};
  logic [7:0] req_byte [4] = '{default: 8'h00};
  int         ready_cnt [4] = '{default: 0};

  int         acc_id_q [$];
  int         acc_cyc_q [$];
  int         act_cyc_q [$];
  int         act_id_q [$];
  logic [7:0] act_data_q [$];

  tx_byte_arbiter #(.NREQ(4), .GAP_CYCLES(2), .ACK_TIMEOUT(16)) u_dut (
    .i_clock(clk), .i_reset(rst), .i_req_valid(req_valid), .i_req_data(req_data),
    .o_req_ready(req_ready), .o_data(o_data), .o_act(o_act), .i_busy(busy_model),
    .o_grant_id(o_grant_id), .o_active(o_active), .o_err(o_err)
  );

  tx_byte_arbiter #(.NREQ(4), .GAP_CYCLES(0), .ACK_TIMEOUT(16)) u_dut_nogap (
    .i_clock(clk), .i_reset(rst), .i_req_valid(valid2), .i_req_data(data2),
    .o_req_ready(ready2), .o_data(dout2), .o_act(act2), .i_busy(busy2),
    .o_grant_id(gid2), .o_active(active2), .o_err(err2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Transmitter: busy rises tx_ack cycles after the strobe and stays high tx_len cycles.
  initial begin
    busy_model = 1'b0;
    forever begin
      @(negedge clk);
      if (o_act === 1'b1 && tx_en) begin
        repeat (tx_ack) @(negedge clk);
        busy_model = 1'b1;
        repeat (tx_len) @(negedge clk);
        busy_model = 1'b0;
      end
    end
  end

  // Requesters: each holds valid while it still has bytes (want > taken).
  initial begin
    logic [3:0] acc;
    req_valid = 4'b0000;
    req_data  = 32'h0000_0000;
    forever begin
      @(posedge clk);
      acc = req_valid & req_ready & {4{~rst}};
      #1;
      for (int n = 0; n < 4; n++) begin
        if (acc[n]) begin
          taken[n]++;
          acc_id_q.push_back(n);
          acc_cyc_q.push_back(cyc);
        end
        req_valid[n]        = (want[n] > taken[n]);
        req_data[8*n +: 8]  = req_byte[n];
      end
    end
  end

  // Log every strobe and every ready pulse.
  initial begin
    forever begin
      @(negedge clk);
      if (o_act === 1'b1) begin
        act_cyc_q.push_back(cyc);
        act_id_q.push_back(int'(o_grant_id));
        act_data_q.push_back(o_data);
      end
      for (int n = 0; n < 4; n++) begin
        if (req_ready[n] === 1'b1) ready_cnt[n]++;
      end
    end
  end

  task automatic wait_acts(input int n, input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit && !ok; i++) begin
      @(negedge clk); #1;
      ok = (act_cyc_q.size() >= n);
    end
  endtask

  task automatic wait_idle(input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit && !ok; i++) begin
      @(negedge clk); #1;
      ok = (o_active === 1'b0);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk); #1;
    total++; if (o_act !== 1'b0) begin bad++; $display("FAIL reset_act: got %b expected 0", o_act); end
    total++; if (o_data !== 8'h00) begin bad++; $display("FAIL reset_data: got %h expected 00", o_data); end
    total++; if (o_grant_id !== 3'd0) begin bad++; $display("FAIL reset_grant: got %0d expected 0", o_grant_id); end
    total++; if (o_active !== 1'b0) begin bad++; $display("FAIL reset_active: got %b expected 0", o_active); end
    total++; if (o_err !== 1'b0) begin bad++; $display("FAIL reset_err: got %b expected 0", o_err); end
    total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL reset_ready: got %b expected 0000", req_ready); end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    total++; if (o_active !== 1'b0) begin bad++; $display("FAIL idle_no_req: got active=%b expected 0", o_active); end
    total++; if (active2 !== 1'b0) begin bad++; $display("FAIL idle_no_req2: got active=%b expected 0", active2); end
  endtask

  task automatic test_single();
    int ab, b;
    bit ok;
    ab = acc_id_q.size();
    b  = act_cyc_q.size();
    tx_en = 1'b1; tx_ack = 2; tx_len = 10;
    req_byte[2] = 8'h05;
    want[2] = want[2] + 2;
    wait_acts(b + 2, 200, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL single_wait: got %0d strobes expected 2", act_cyc_q.size() - b); $fatal(1, "stalled"); end
    total++; if (acc_id_q[ab] !== 2) begin bad++; $display("FAIL single_accept_id: got %0d expected 2", acc_id_q[ab]); end
    total++; if (act_cyc_q[b] !== acc_cyc_q[ab]) begin bad++; $display("FAIL single_latency: strobe cycle %0d expected %0d", act_cyc_q[b], acc_cyc_q[ab]); end
    total++; if (act_data_q[b] !== 8'h05) begin bad++; $display("FAIL single_data: got %h expected 05", act_data_q[b]); end
    total++; if (act_id_q[b] !== 2) begin bad++; $display("FAIL single_grant: got %0d expected 2", act_id_q[b]); end
    // 1 issue + 2 ack + 10 busy + 2 gap + 1 arbitration
    total++; if (act_cyc_q[b+1] - act_cyc_q[b] !== 16) begin bad++; $display("FAIL single_spacing: got %0d expected 16", act_cyc_q[b+1] - act_cyc_q[b]); end
    wait_idle(100, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL single_idle: got active=%b expected 0", o_active); $fatal(1, "stalled"); end
    total++; if (o_data !== 8'h05) begin bad++; $display("FAIL single_hold_data: got %h expected 05", o_data); end
    total++; if (o_grant_id !== 3'd2) begin bad++; $display("FAIL single_hold_grant: got %0d expected 2", o_grant_id); end
    total++; if (o_err !== 1'b0) begin bad++; $display("FAIL single_err: got %b expected 0", o_err); end
  endtask

  task automatic test_round_robin();
    int b;
    bit ok;
    int exp_id [5] = '{0, 1, 2, 3, 0};
    int rc0 [4];
    logic [7:0] ed;
    do_reset();
    tx_ack = 1; tx_len = 1;
    for (int n = 0; n < 4; n++) begin
      rc0[n] = ready_cnt[n];
      req_byte[n] = 8'hA0 + 8'(n);
    end
    b = act_cyc_q.size();
    for (int n = 0; n < 4; n++) want[n] = want[n] + 2;
    wait_acts(b + 8, 400, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL rr_wait: got %0d strobes expected 8", act_cyc_q.size() - b); $fatal(1, "stalled"); end
    for (int i = 0; i < 5; i++) begin
      ed = 8'hA0 + 8'(exp_id[i]);
      total++; if (act_id_q[b+i] !== exp_id[i]) begin bad++; $display("FAIL rr_order[%0d]: got %0d expected %0d", i, act_id_q[b+i], exp_id[i]); end
      total++; if (act_data_q[b+i] !== ed) begin bad++; $display("FAIL rr_data[%0d]: got %h expected %h", i, act_data_q[b+i], ed); end
    end
    wait_idle(100, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL rr_idle: got active=%b expected 0", o_active); $fatal(1, "stalled"); end
    for (int n = 0; n < 4; n++) begin
      total++; if (ready_cnt[n] - rc0[n] !== 2) begin bad++; $display("FAIL rr_ready_pulses[%0d]: got %0d expected 2", n, ready_cnt[n] - rc0[n]); end
    end
  endtask

  task automatic test_timeout();
    int b;
    bit ok;
    tx_en = 1'b0;
    b = act_cyc_q.size();
    req_byte[1] = 8'h11;
    want[1] = want[1] + 1;
    wait_acts(b + 1, 50, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL to_wait: got %0d strobes expected 1", act_cyc_q.size() - b); $fatal(1, "stalled"); end
    // Strobe cycle k; WAIT_START spans k+1..k+16, error visible from k+17.
    repeat (16) @(negedge clk);
    #1;
    total++; if (o_err !== 1'b0) begin bad++; $display("FAIL to_err_early: got %b expected 0", o_err); end
    total++; if (o_active !== 1'b1) begin bad++; $display("FAIL to_active: got %b expected 1", o_active); end
    @(negedge clk); #1;
    total++; if (o_err !== 1'b1) begin bad++; $display("FAIL to_err_set: got %b expected 1", o_err); end
    repeat (2) @(negedge clk);
    #1;
    total++; if (o_active !== 1'b0) begin bad++; $display("FAIL to_back_idle: got %b expected 0", o_active); end
    tx_en = 1'b1; tx_ack = 1; tx_len = 2;
    b = act_cyc_q.size();
    req_byte[3] = 8'h33;
    want[3] = want[3] + 1;
    wait_acts(b + 1, 50, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL to_next_wait: got %0d strobes expected 1", act_cyc_q.size() - b); $fatal(1, "stalled"); end
    total++; if (act_id_q[b] !== 3) begin bad++; $display("FAIL to_next_grant: got %0d expected 3", act_id_q[b]); end
    total++; if (act_data_q[b] !== 8'h33) begin bad++; $display("FAIL to_next_data: got %h expected 33", act_data_q[b]); end
    wait_idle(100, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL to_next_idle: got active=%b expected 0", o_active); $fatal(1, "stalled"); end
    total++; if (o_err !== 1'b1) begin bad++; $display("FAIL to_err_sticky: got %b expected 1", o_err); end
  endtask

  task automatic test_reset_mid();
    int b;
    bit ok;
    tx_ack = 1; tx_len = 20;
    b = act_cyc_q.size();
    req_byte[2] = 8'h22;
    want[2] = want[2] + 1;
    wait_acts(b + 1, 50, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL rm_wait: got %0d strobes expected 1", act_cyc_q.size() - b); $fatal(1, "stalled"); end
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    total++; if (o_active !== 1'b0) begin bad++; $display("FAIL rm_active: got %b expected 0", o_active); end
    total++; if (o_data !== 8'h00) begin bad++; $display("FAIL rm_data: got %h expected 00", o_data); end
    total++; if (o_grant_id !== 3'd0) begin bad++; $display("FAIL rm_grant: got %0d expected 0", o_grant_id); end
    total++; if (o_err !== 1'b0) begin bad++; $display("FAIL rm_err: got %b expected 0", o_err); end
    total++; if (o_act !== 1'b0) begin bad++; $display("FAIL rm_act: got %b expected 0", o_act); end
    total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL rm_ready: got %b expected 0000", req_ready); end
    req_byte[0] = 8'hB0;
    req_byte[3] = 8'hB3;
    want[0] = want[0] + 1;
    want[3] = want[3] + 1;
    repeat (2) @(negedge clk);
    b = act_cyc_q.size();
    rst = 1'b0;
    wait_acts(b + 2, 200, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL rm_after_wait: got %0d strobes expected 2", act_cyc_q.size() - b); $fatal(1, "stalled"); end
    total++; if (act_id_q[b] !== 0) begin bad++; $display("FAIL rm_first_grant: got %0d expected 0", act_id_q[b]); end
    total++; if (act_data_q[b] !== 8'hB0) begin bad++; $display("FAIL rm_first_data: got %h expected b0", act_data_q[b]); end
    total++; if (act_id_q[b+1] !== 3) begin bad++; $display("FAIL rm_second_grant: got %0d expected 3", act_id_q[b+1]); end
    wait_idle(100, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL rm_idle: got active=%b expected 0", o_active); $fatal(1, "stalled"); end
  endtask

  task automatic test_no_gap();
    int  t_act [2];
    int  viol;
    bit  seen;
    viol  = 0;
    data2 = 32'h0000_5A00;
    valid2 = 4'b0010;
    for (int s = 0; s < 2; s++) begin
      seen = 1'b0;
      for (int w = 0; w < 60 && !seen; w++) begin
        @(negedge clk); #1;
        if (active2 === 1'b1 && ready2 !== 4'b0000) viol++;
        if (act2 === 1'b1) begin
          seen = 1'b1;
          t_act[s] = cyc;
          total++; if (dout2 !== 8'h5A) begin bad++; $display("FAIL ng_data[%0d]: got %h expected 5a", s, dout2); end
          total++; if (gid2 !== 3'd1) begin bad++; $display("FAIL ng_grant[%0d]: got %0d expected 1", s, gid2); end
        end
      end
      total++;
      if (!seen) begin bad++; $display("FAIL ng_wait[%0d]: got no strobe expected one", s); $fatal(1, "stalled"); end
      if (s == 1) valid2 = 4'b0000;
      @(negedge clk); #1;
      if (active2 === 1'b1 && ready2 !== 4'b0000) viol++;
      busy2 = 1'b1;
      repeat (3) begin
        @(negedge clk); #1;
        if (active2 === 1'b1 && ready2 !== 4'b0000) viol++;
      end
      busy2 = 1'b0;
    end
    // 2 + 1 ack + 3 busy
    total++; if (t_act[1] - t_act[0] !== 6) begin bad++; $display("FAIL ng_spacing: got %0d expected 6", t_act[1] - t_act[0]); end
    total++; if (viol !== 0) begin bad++; $display("FAIL ng_ready_while_active: got %0d cycles expected 0", viol); end
    repeat (3) @(negedge clk);
    #1;
    total++; if (active2 !== 1'b0) begin bad++; $display("FAIL ng_idle: got %b expected 0", active2); end
  endtask

  initial begin
    rst    = 1'b1;
    valid2 = 4'b0000;
    data2  = 32'h0000_0000;
    busy2  = 1'b0;
    repeat (3) @(negedge clk);
    test_reset();
    test_single();
    test_round_robin();
    test_timeout();
    test_reset_mid();
    test_no_gap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
